// File: rtl/pos_trigger.sv
// Position-compare trigger: fires a fixed-width output pulse when pos_in reaches
// a latched target, then enforces a quiet holdoff before re-arming is possible.
module pos_trigger #(
    parameter bit          INVERT = 1'b0,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             cancel,
    input  logic             dir,
    input  logic [31:0]      pos_in,
    input  logic [31:0]      target,
    input  logic [31:0]      pulse_len,
    input  logic [31:0]      holdoff,
    output logic             sig_out,
    output logic             fired,
    output logic             busy,
    output logic [31:0]      pos_out,
    output logic [31:0]      overshoot,
    output logic [CNT_W-1:0] cycles
);

    localparam int unsigned POS_W = 32;

    // Physical output levels; all internal decisions are active-high.
    localparam logic SIG_ACT  = INVERT ? 1'b0 : 1'b1;
    localparam logic SIG_IDLE = INVERT ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state;
    logic [POS_W-1:0] tgt_l;
    logic [POS_W-1:0] len_l;
    logic [POS_W-1:0] hold_l;
    logic [POS_W-1:0] cnt;
    logic             dir_l;

    logic [POS_W-1:0] diff;
    logic             diff_neg;
    logic             diff_zero;
    logic             hit;
    logic [POS_W-1:0] len_sel;

    // Wrapping subtraction read as signed keeps the compare correct across 0x7FFFFFFF/0x80000000.
    assign diff      = pos_in - tgt_l;
    assign diff_neg  = diff[POS_W-1];
    assign diff_zero = (diff == '0);
    assign hit       = dir_l ? !diff_neg : (diff_neg || diff_zero);

    // A zero-length request still produces a single-clock pulse.
    assign len_sel   = (pulse_len == '0) ? POS_W'(1) : pulse_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            sig_out   <= SIG_IDLE;
            fired     <= 1'b0;
            busy      <= 1'b0;
            pos_out   <= '0;
            overshoot <= '0;
            cycles    <= '0;
            cnt       <= '0;
            tgt_l     <= '0;
            len_l     <= '0;
            hold_l    <= '0;
            dir_l     <= 1'b0;
        end else begin
            fired <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm && !cancel) begin
                        tgt_l  <= target;
                        dir_l  <= dir;
                        len_l  <= len_sel;
                        hold_l <= holdoff;
                        busy   <= 1'b1;
                        state  <= S_ARMED;
                    end
                end

                S_ARMED: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (hit) begin
                        sig_out   <= SIG_ACT;
                        fired     <= 1'b1;
                        pos_out   <= pos_in;
                        overshoot <= diff;
                        cycles    <= cycles + CNT_W'(1);
                        cnt       <= len_l - POS_W'(1);
                        state     <= S_PULSE;
                    end
                end

                // Pulse runs to completion; arm and cancel have no effect here.
                S_PULSE: begin
                    if (cnt == '0) begin
                        sig_out <= SIG_IDLE;
                        if (hold_l == '0) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            cnt   <= hold_l - POS_W'(1);
                            state <= S_HOLD;
                        end
                    end else begin
                        cnt <= cnt - POS_W'(1);
                    end
                end

                S_HOLD: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - POS_W'(1);
                    end
                end

                default: begin
                    sig_out <= SIG_IDLE;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pos_trigger.sv
// Scoreboard bench for pos_trigger: stimulus queues expected fire records, a
// negedge monitor checks each fire's capture values, pulse width and holdoff.
module tb_pos_trigger;

    localparam int unsigned CNT_W = 8;
    localparam int          BUDGET = 300;

    logic             clk = 1'b0;
    logic             reset, arm, cancel, dir;
    logic [31:0]      pos_in, target, pulse_len, holdoff;
    logic             sig_out, fired, busy;
    logic [31:0]      pos_out, overshoot;
    logic [CNT_W-1:0] cycles;
    logic             sig_inv, fired_inv, busy_inv;
    logic [31:0]      pos_out_inv, overshoot_inv;
    logic [CNT_W-1:0] cycles_inv;

    int step;
    int n_tests = 0;
    int n_fail  = 0;
    int exp_cycles = 0;

    typedef struct {
        logic [31:0] pos;
        logic [31:0] ov;
        int          cyc;
        int          len;
        int          hold;
        bit          chk_width;
    } fire_t;

    fire_t sb[$];

    always #5 clk = ~clk;

    pos_trigger #(.INVERT(1'b0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .cancel(cancel), .dir(dir),
        .pos_in(pos_in), .target(target), .pulse_len(pulse_len), .holdoff(holdoff),
        .sig_out(sig_out), .fired(fired), .busy(busy), .pos_out(pos_out),
        .overshoot(overshoot), .cycles(cycles)
    );

    pos_trigger #(.INVERT(1'b1), .CNT_W(CNT_W)) dut_inv (
        .clk(clk), .reset(reset), .arm(arm), .cancel(cancel), .dir(dir),
        .pos_in(pos_in), .target(target), .pulse_len(pulse_len), .holdoff(holdoff),
        .sig_out(sig_inv), .fired(fired_inv), .busy(busy_inv), .pos_out(pos_out_inv),
        .overshoot(overshoot_inv), .cycles(cycles_inv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
        pos_in = pos_in + 32'(step);
    endtask

    task automatic do_arm(input logic [31:0] tgt, input logic d, input int len, input int hold);
        target    = tgt;
        dir       = d;
        pulse_len = 32'(len);
        holdoff   = 32'(hold);
        arm       = 1'b1;
        step_clk();
        arm       = 1'b0;
    endtask

    task automatic expect_fire(input logic [31:0] p, input logic [31:0] ov,
                               input int len, input int hold, input bit cw);
        fire_t e;
        exp_cycles++;
        e.pos = p; e.ov = ov; e.cyc = exp_cycles;
        e.len = (len == 0) ? 1 : len; e.hold = hold; e.chk_width = cw;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while (busy !== 1'b0 && b < BUDGET) begin step_clk(); b++; end
        chk({name, "_idle_timeout"}, 32'(b < BUDGET), 32'd1);
        step_clk();
        step_clk();
    endtask

    task automatic wait_sig(input logic lvl, input string name);
        int b = 0;
        while (sig_out !== lvl && b < BUDGET) begin step_clk(); b++; end
        chk({name, "_sig_timeout"}, 32'(b < BUDGET), 32'd1);
    endtask

    // Monitor: every fired strobe must match the oldest queued expectation.
    initial begin
        fire_t e;
        int n, h;
        forever begin
            @(negedge clk);
            if (fired === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_fire", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pos_out", pos_out, e.pos);
                    chk("overshoot", overshoot, e.ov);
                    chk("cycles", 32'(cycles), 32'(e.cyc));
                    chk("sig_active", 32'(sig_out), 32'd1);
                    chk("inv_sig_active_low", 32'(sig_inv), 32'd0);
                    n = 1;
                    @(negedge clk);
                    while (sig_out === 1'b1 && n < BUDGET) begin
                        if (n == 1) chk("fired_single", 32'(fired), 32'd0);
                        n++;
                        @(negedge clk);
                    end
                    if (e.chk_width) chk("pulse_width", 32'(n), 32'(e.len));
                    chk("inv_sig_idle_high", 32'(sig_inv), 32'd1);
                    h = 0;
                    while (busy === 1'b1 && h < BUDGET) begin
                        chk("quiet_sig", 32'(sig_out), 32'd0);
                        h++;
                        @(negedge clk);
                    end
                    if (e.chk_width) chk("holdoff_len", 32'(h), 32'(e.hold));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; arm = 1'b0; cancel = 1'b0; dir = 1'b1; step = 1;
        pos_in = 32'd0; target = 32'd0; pulse_len = 32'd0; holdoff = 32'd0;
        step_clk();
        step_clk();
        reset = 1'b0;

        // Reset state
        chk("rst_sig", 32'(sig_out), 32'd0);
        chk("rst_sig_inv", 32'(sig_inv), 32'd1);
        chk("rst_fired", 32'(fired), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pos_out", pos_out, 32'd0);
        chk("rst_overshoot", overshoot, 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);

        // Basic fire at 100 counting up
        pos_in = 32'd50; step = 1;
        expect_fire(32'd100, 32'd0, 20, 10, 1'b1);
        do_arm(32'd100, 1'b1, 20, 10);
        chk("armed_busy", 32'(busy), 32'd1);
        wait_idle("basic");

        // Already passed, dir=1: fires on first ARMED cycle at pos 41
        pos_in = 32'd40; step = 1;
        expect_fire(32'd41, 32'd31, 3, 0, 1'b1);
        do_arm(32'd10, 1'b1, 3, 0);
        wait_idle("passed_up");

        // Counting down, dir=0, exact hit at 30
        pos_in = 32'd35; step = -1;
        expect_fire(32'd30, 32'd0, 5, 2, 1'b1);
        do_arm(32'd30, 1'b0, 5, 2);
        wait_idle("down_hit");

        // Counting down, dir=0, already passed: 49 - 60 = -11
        pos_in = 32'd50; step = -1;
        expect_fire(32'd49, 32'hFFFF_FFF5, 2, 1, 1'b1);
        do_arm(32'd60, 1'b0, 2, 1);
        wait_idle("down_passed");

        // Cancel while ARMED: no fire, count unchanged
        pos_in = 32'd0; step = 1;
        do_arm(32'd1000, 1'b1, 4, 4);
        step_clk(); step_clk();
        cancel = 1'b1;
        step_clk();
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_cycles", 32'(cycles), 32'(exp_cycles));
        for (int i = 0; i < 5; i++) step_clk();
        chk("cancel_no_sig", 32'(sig_out), 32'd0);

        // arm together with cancel in IDLE is refused
        target = 32'd0; arm = 1'b1; cancel = 1'b1;
        step_clk();
        arm = 1'b0; cancel = 1'b0;
        chk("arm_cancel_busy", 32'(busy), 32'd0);

        // arm during PULSE and HOLDOFF is ignored (a stale passed target would fire at once)
        pos_in = 32'd300; step = 1;
        expect_fire(32'd305, 32'd0, 4, 4, 1'b1);
        do_arm(32'd305, 1'b1, 4, 4);
        wait_sig(1'b1, "ign_pulse");
        step_clk();
        target = 32'd0; arm = 1'b1;
        step_clk();
        arm = 1'b0;
        wait_sig(1'b0, "ign_hold");
        arm = 1'b1;
        step_clk();
        arm = 1'b0;
        wait_idle("ignore");
        for (int i = 0; i < 4; i++) step_clk();
        chk("ignore_busy", 32'(busy), 32'd0);
        chk("ignore_cycles", 32'(cycles), 32'(exp_cycles));

        // pulse_len = 0 gives a single-clock pulse
        pos_in = 32'd500; step = 1;
        expect_fire(32'd501, 32'd401, 0, 0, 1'b1);
        do_arm(32'd100, 1'b1, 0, 0);
        wait_idle("len0");

        // Wrap across 0x7FFFFFFF: must not fire at arm time
        pos_in = 32'h7FFF_FFF0; step = 1;
        expect_fire(32'h8000_0005, 32'd0, 3, 2, 1'b1);
        do_arm(32'h8000_0005, 1'b1, 3, 2);
        step_clk();
        chk("wrap_no_early_sig", 32'(sig_out), 32'd0);
        wait_idle("wrap");

        // Reset during the 5th clock of a 20-clock pulse
        pos_in = 32'd200; step = 1;
        expect_fire(32'd201, 32'd101, 20, 5, 1'b0);
        do_arm(32'd100, 1'b1, 20, 5);
        wait_sig(1'b1, "rst_mid");
        for (int i = 0; i < 4; i++) step_clk();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        exp_cycles = 0;
        chk("midrst_sig", 32'(sig_out), 32'd0);
        chk("midrst_sig_inv", 32'(sig_inv), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pos_out", pos_out, 32'd0);
        chk("midrst_overshoot", overshoot, 32'd0);
        chk("midrst_cycles", 32'(cycles), 32'd0);
        step_clk(); step_clk();

        // Normal arm after reset
        pos_in = 32'd10; step = 1;
        expect_fire(32'd15, 32'd0, 6, 3, 1'b1);
        do_arm(32'd15, 1'b1, 6, 3);
        wait_idle("after_rst");

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
